// File: rtl/control_multicanal.sv
// ============================================================================
// Module      : control_multicanal
// Description : Round-robin multi-channel sensor controller with latched
//               per-channel alerts and hysteresis on alert clearing.
//               Optional idle watchdog enabled by CONTROL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_multicanal #(
    parameter int N_CANALES = 4,
    parameter int CH_W      = 2,
    parameter int N_CONFIRM = 3,
    parameter int CNT_W     = 2,
    parameter int TIMEOUT   = 1000,
    parameter int TO_W      = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CANALES-1:0] Dato_listo,
    input  logic [N_CANALES-1:0] Peligro,
    output logic [N_CANALES-1:0] Ack,
    output logic                 Activar_Decidir,
    output logic [CH_W-1:0]      Canal_sel,
    output logic [N_CANALES-1:0] Alerta,
    output logic [1:0]           Estados,
    output logic                 Timeout
);

    typedef enum logic [1:0] {
        LEER    = 2'b01,
        DECIDIR = 2'b10,
        ALERTA  = 2'b11
    } state_t;

    localparam logic [N_CANALES-1:0] c_one     = N_CANALES'(1);
    localparam logic [CNT_W:0]       c_confirm = (CNT_W+1)'(N_CONFIRM);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CH_W-1:0]        r_ptr;
    logic [CH_W-1:0]        r_canal;
    logic                   r_peligro;
    logic [N_CANALES-1:0]   r_alerta;
    logic [CNT_W-1:0]       r_cnt [N_CANALES];

    logic                   w_arb_state;
    logic                   w_grant;
    logic [CH_W-1:0]        w_winner;
    logic [N_CANALES-1:0]   w_alerta_next;
    logic [CNT_W:0]         w_cnt_inc;
    logic [CNT_W-1:0]       w_cnt_sel_next;

    assign w_arb_state = (r_state == LEER) || (r_state == ALERTA);
    assign w_grant     = w_arb_state && (|Dato_listo);

    // First requester strictly after the last served channel, wrapping around.
    always_comb begin
        w_winner = '0;
        for (int i = N_CANALES; i >= 1; i--) begin
            if (Dato_listo[(int'(r_ptr) + i) % N_CANALES])
                w_winner = CH_W'((int'(r_ptr) + i) % N_CANALES);
        end
    end

    // Alert/hysteresis update for the channel being decided.
    always_comb begin
        w_alerta_next  = r_alerta;
        w_cnt_sel_next = r_cnt[r_canal];
        w_cnt_inc      = {1'b0, r_cnt[r_canal]} + 1'b1;
        if (r_state == DECIDIR) begin
            if (r_peligro) begin
                w_alerta_next[r_canal] = 1'b1;
                w_cnt_sel_next         = '0;
            end else if (r_alerta[r_canal]) begin
                if (w_cnt_inc == c_confirm) begin
                    w_alerta_next[r_canal] = 1'b0;
                    w_cnt_sel_next         = '0;
                end else begin
                    w_cnt_sel_next = w_cnt_inc[CNT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LEER, ALERTA: if (|Dato_listo) w_state_next = DECIDIR;
            DECIDIR:      w_state_next = (|w_alerta_next) ? ALERTA : LEER;
            default:      w_state_next = LEER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= LEER;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= CH_W'(N_CANALES - 1);
            r_canal   <= '0;
            r_peligro <= 1'b0;
            r_alerta  <= '0;
            for (int i = 0; i < N_CANALES; i++) r_cnt[i] <= '0;
        end else begin
            if (w_grant) begin
                r_ptr     <= w_winner;
                r_canal   <= w_winner;
                r_peligro <= Peligro[w_winner];
            end
            if (r_state == DECIDIR) begin
                r_alerta       <= w_alerta_next;
                r_cnt[r_canal] <= w_cnt_sel_next;
            end
        end
    end

    assign Estados         = r_state;
    assign Activar_Decidir = (r_state == DECIDIR);
    assign Ack             = (r_state == DECIDIR) ? (c_one << r_canal) : '0;
    assign Canal_sel       = r_canal;
    assign Alerta          = r_alerta;

`ifdef CONTROL_TIMEOUT_EN
    logic [TO_W-1:0] r_idle;
    logic            r_timeout;

    // Idle counter saturates at TIMEOUT-1; the flag holds until a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else if (w_grant) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else if (w_arb_state) begin
            if (r_idle == TO_W'(TIMEOUT - 1)) r_timeout <= 1'b1;
            else                              r_idle    <= r_idle + 1'b1;
        end else begin
            r_idle <= '0;
        end
    end

    assign Timeout = r_timeout;
`else
    logic w_unused_to;
    assign w_unused_to = ^(TO_W'(TIMEOUT));
    assign Timeout     = 1'b0;
`endif

endmodule

`default_nettype wire
